// File: rtl/stopwatch_datapath.sv
// Stopwatch timekeeping: tick prescaler plus cascaded cs/s/m/h counters.
// Optional lap snapshot display enabled by defining STOPWATCH_LAP_EN.
module stopwatch_datapath #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int TICK_HZ     = 100
) (
  input  logic       clk,
  input  logic       reset,
`ifdef STOPWATCH_LAP_EN
  input  logic       i_lap,
`endif
  input  logic       i_run_stop,
  input  logic       i_clear,
  output logic [6:0] o_msec,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hour,
  output logic       o_tick
);

  localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int TW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [TW-1:0] TC_MAX = TW'(DIV - 1);

  if (DIV < 2 || (CLK_FREQ_HZ % TICK_HZ) != 0) begin : g_bad_div
    $error("stopwatch_datapath: DIV must be >= 2 and exact");
  end

  logic [TW-1:0] r_tick_cnt;
  logic [6:0]    r_msec;
  logic [5:0]    r_sec;
  logic [5:0]    r_min;
  logic [4:0]    r_hour;
  logic          r_tick;

  logic [TW-1:0] w_tick_nxt;
  logic [6:0]    w_msec_nxt;
  logic [5:0]    w_sec_nxt;
  logic [5:0]    w_min_nxt;
  logic [4:0]    w_hour_nxt;
  logic          w_pulse;
  logic          w_c_ms;
  logic          w_c_s;
  logic          w_c_m;

  // Next live state: clear beats run; carries ripple within one edge.
  always_comb begin
    w_tick_nxt = r_tick_cnt;
    w_msec_nxt = r_msec;
    w_sec_nxt  = r_sec;
    w_min_nxt  = r_min;
    w_hour_nxt = r_hour;
    w_pulse    = 1'b0;
    w_c_ms     = 1'b0;
    w_c_s      = 1'b0;
    w_c_m      = 1'b0;
    if (i_clear) begin
      w_tick_nxt = '0;
      w_msec_nxt = '0;
      w_sec_nxt  = '0;
      w_min_nxt  = '0;
      w_hour_nxt = '0;
    end else if (i_run_stop) begin
      if (r_tick_cnt == TC_MAX) begin
        w_tick_nxt = '0;
        w_pulse    = 1'b1;
        if (r_msec == 7'd99) begin
          w_msec_nxt = '0;
          w_c_ms     = 1'b1;
        end else begin
          w_msec_nxt = r_msec + 7'd1;
        end
        if (w_c_ms) begin
          if (r_sec == 6'd59) begin
            w_sec_nxt = '0;
            w_c_s     = 1'b1;
          end else begin
            w_sec_nxt = r_sec + 6'd1;
          end
        end
        if (w_c_s) begin
          if (r_min == 6'd59) begin
            w_min_nxt = '0;
            w_c_m     = 1'b1;
          end else begin
            w_min_nxt = r_min + 6'd1;
          end
        end
        if (w_c_m) begin
          if (r_hour == 5'd23) begin
            w_hour_nxt = '0;
          end else begin
            w_hour_nxt = r_hour + 5'd1;
          end
        end
      end else begin
        w_tick_nxt = r_tick_cnt + TW'(1);
      end
    end
  end

  // Live prescaler, counters and tick pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tick_cnt <= '0;
      r_msec     <= '0;
      r_sec      <= '0;
      r_min      <= '0;
      r_hour     <= '0;
      r_tick     <= 1'b0;
    end else begin
      r_tick_cnt <= w_tick_nxt;
      r_msec     <= w_msec_nxt;
      r_sec      <= w_sec_nxt;
      r_min      <= w_min_nxt;
      r_hour     <= w_hour_nxt;
      r_tick     <= w_pulse;
    end
  end

  assign o_tick = r_tick;

`ifdef STOPWATCH_LAP_EN
  logic       r_hold;
  logic [6:0] r_s_msec;
  logic [5:0] r_s_sec;
  logic [5:0] r_s_min;
  logic [4:0] r_s_hour;
  logic [6:0] r_o_msec;
  logic [5:0] r_o_sec;
  logic [5:0] r_o_min;
  logic [4:0] r_o_hour;
  logic       w_hold_nxt;
  logic       w_take;

  // Lap toggle; clear forces live display and wins over a lap pulse.
  always_comb begin
    w_hold_nxt = r_hold;
    if (i_clear) begin
      w_hold_nxt = 1'b0;
    end else if (i_lap) begin
      w_hold_nxt = ~r_hold;
    end
    w_take = w_hold_nxt & ~r_hold;
  end

  // Snapshot captures post-update live values on entering hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold   <= 1'b0;
      r_s_msec <= '0;
      r_s_sec  <= '0;
      r_s_min  <= '0;
      r_s_hour <= '0;
    end else begin
      r_hold <= w_hold_nxt;
      if (i_clear) begin
        r_s_msec <= '0;
        r_s_sec  <= '0;
        r_s_min  <= '0;
        r_s_hour <= '0;
      end else if (w_take) begin
        r_s_msec <= w_msec_nxt;
        r_s_sec  <= w_sec_nxt;
        r_s_min  <= w_min_nxt;
        r_s_hour <= w_hour_nxt;
      end
    end
  end

  // Registered display: snapshot while holding, else live.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_o_msec <= '0;
      r_o_sec  <= '0;
      r_o_min  <= '0;
      r_o_hour <= '0;
    end else if (w_hold_nxt && !w_take) begin
      r_o_msec <= r_s_msec;
      r_o_sec  <= r_s_sec;
      r_o_min  <= r_s_min;
      r_o_hour <= r_s_hour;
    end else begin
      r_o_msec <= w_msec_nxt;
      r_o_sec  <= w_sec_nxt;
      r_o_min  <= w_min_nxt;
      r_o_hour <= w_hour_nxt;
    end
  end

  assign o_msec = r_o_msec;
  assign o_sec  = r_o_sec;
  assign o_min  = r_o_min;
  assign o_hour = r_o_hour;
`else
  assign o_msec = r_msec;
  assign o_sec  = r_sec;
  assign o_min  = r_min;
  assign o_hour = r_hour;
`endif

endmodule

// File: tb/tb_stopwatch_datapath.sv
// Bench for stopwatch_datapath: elapsed-centisecond model plus
// directed scenarios; lap scenario runs when STOPWATCH_LAP_EN is set.
module tb_stopwatch_datapath;

  localparam int CF  = 1000;
  localparam int TH  = 100;
  localparam int DIV = CF / TH;
  localparam int DAY = 8640000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic       clr = 1'b0;
  logic       lap = 1'b0;
  logic [6:0] o_msec;
  logic [5:0] o_sec;
  logic [5:0] o_min;
  logic [4:0] o_hour;
  logic       o_tick;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  int m_cs;
  int m_ph;
  int m_snap;
  bit m_tick;
  bit m_hold;
  bit ld_req = 1'b0;
  int ld_cs = 0;
  int ld_ph = 0;

  always #5 clk = ~clk;

  stopwatch_datapath #(
    .CLK_FREQ_HZ(CF),
    .TICK_HZ(TH)
  ) dut (
    .clk(clk),
    .reset(reset),
`ifdef STOPWATCH_LAP_EN
    .i_lap(lap),
`endif
    .i_run_stop(run),
    .i_clear(clr),
    .o_msec(o_msec),
    .o_sec(o_sec),
    .o_min(o_min),
    .o_hour(o_hour),
    .o_tick(o_tick)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: elapsed time as a single centisecond count plus phase.
  always @(posedge clk or posedge reset) begin : model
    int cs_n;
    bit t_n;
    if (reset) begin
      m_cs <= 0;
      m_ph <= 0;
      m_tick <= 1'b0;
      m_hold <= 1'b0;
      m_snap <= 0;
    end else if (ld_req) begin
      m_cs <= ld_cs;
      m_ph <= ld_ph;
      m_tick <= 1'b0;
    end else if (clr) begin
      m_cs <= 0;
      m_ph <= 0;
      m_tick <= 1'b0;
      m_hold <= 1'b0;
      m_snap <= 0;
    end else begin
      cs_n = m_cs;
      t_n = 1'b0;
      if (run) begin
        if (m_ph == DIV - 1) begin
          m_ph <= 0;
          cs_n = (m_cs + 1) % DAY;
          t_n = 1'b1;
        end else begin
          m_ph <= m_ph + 1;
        end
      end
      m_cs <= cs_n;
      m_tick <= t_n;
      if (lap) begin
        m_hold <= !m_hold;
        if (!m_hold) m_snap <= cs_n;
      end
    end
  end

  // Every-cycle comparison of DUT against the model.
  always @(negedge clk) begin : cmp
    int sh;
    if (!reset && chk_en) begin
      sh = m_hold ? m_snap : m_cs;
      chk("cyc_msec", int'(o_msec), sh % 100);
      chk("cyc_sec", int'(o_sec), (sh / 100) % 60);
      chk("cyc_min", int'(o_min), (sh / 6000) % 60);
      chk("cyc_hour", int'(o_hour), (sh / 360000) % 24);
      chk("cyc_tick", int'(o_tick), int'(m_tick));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("rst_msec", int'(o_msec), 0);
    chk("rst_hour", int'(o_hour), 0);
    chk("rst_tick", int'(o_tick), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_en = 1'b1;

    run = 1'b1;
    step(9);
    chk("first_tick_early", int'(o_tick), 0);
    step(1);
    chk("first_tick", int'(o_tick), 1);
    chk("first_msec", int'(o_msec), 1);
    step(990);
    chk("carry_msec", int'(o_msec), 0);
    chk("carry_sec", int'(o_sec), 1);

    run = 1'b0;
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("clr_sec", int'(o_sec), 0);
    run = 1'b1;
    step(25);
    chk("pre_pause_msec", int'(o_msec), 2);
    run = 1'b0;
    step(50);
    chk("pause_msec", int'(o_msec), 2);
    chk("pause_tick", int'(o_tick), 0);
    run = 1'b1;
    step(4);
    chk("resume_early", int'(o_tick), 0);
    step(1);
    chk("resume_tick", int'(o_tick), 1);
    chk("resume_msec", int'(o_msec), 3);

    run = 1'b0;
    chk_en = 1'b0;
    ld_cs = DAY - 1;
    ld_ph = DIV - 1;
    ld_req = 1'b1;
    force dut.r_tick_cnt = 4'd9;
    force dut.r_msec = 7'd99;
    force dut.r_sec = 6'd59;
    force dut.r_min = 6'd59;
    force dut.r_hour = 5'd23;
    step(1);
    release dut.r_tick_cnt;
    release dut.r_msec;
    release dut.r_sec;
    release dut.r_min;
    release dut.r_hour;
    ld_req = 1'b0;
    chk_en = 1'b1;
    chk("pre_wrap_hour", int'(o_hour), 23);
    chk("pre_wrap_msec", int'(o_msec), 99);
    run = 1'b1;
    step(1);
    chk("wrap_hour", int'(o_hour), 0);
    chk("wrap_min", int'(o_min), 0);
    chk("wrap_sec", int'(o_sec), 0);
    chk("wrap_msec", int'(o_msec), 0);
    chk("wrap_tick", int'(o_tick), 1);

    step(9);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("clr_tick_drop", int'(o_tick), 0);
    chk("clr_msec", int'(o_msec), 0);
    step(9);
    chk("post_clr_early", int'(o_tick), 0);
    step(1);
    chk("post_clr_tick", int'(o_tick), 1);
    chk("post_clr_msec", int'(o_msec), 1);

    clr = 1'b1;
    step(1);
    clr = 1'b0;
    step(1370);
    chk("pre_rst_msec", int'(o_msec), 37);
    chk("pre_rst_sec", int'(o_sec), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_msec", int'(o_msec), 0);
    chk("async_rst_sec", int'(o_sec), 0);
    run = 1'b0;
    step(2);
    reset = 1'b0;
    step(3);
    chk("post_rst_msec", int'(o_msec), 0);
    chk("post_rst_tick", int'(o_tick), 0);
    run = 1'b1;
    step(10);
    chk("post_rst_tick1", int'(o_tick), 1);
    chk("post_rst_msec1", int'(o_msec), 1);

`ifdef STOPWATCH_LAP_EN
    begin
      int nt;
      nt = 0;
      clr = 1'b1;
      step(1);
      clr = 1'b0;
      step(400);
      chk("lap_pre_msec", int'(o_msec), 40);
      lap = 1'b1;
      step(1);
      lap = 1'b0;
      chk("lap_hold_msec", int'(o_msec), 40);
      repeat (299) begin
        step(1);
        if (o_tick) nt++;
      end
      chk("lap_live_ticks", nt, 30);
      chk("lap_frozen_msec", int'(o_msec), 40);
      lap = 1'b1;
      step(1);
      lap = 1'b0;
      chk("lap_release_msec", int'(o_msec), 70);
    end
`endif

    step(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
